// File: rtl/mem_write_checker.sv
// Self-check monitor on the data-memory write bus: scores qualified stores against a
// loadable table of expected (addr, data) pairs. Optional per-byte masking: MWC_BYTE_MASK_EN.

module mwc_entry #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2,
    parameter int IDX    = 0
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    input  logic              cfg_vld_i,
`ifdef MWC_BYTE_MASK_EN
    input  logic [DATA_W/8-1:0] cfg_mask_i,
`endif
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              vld_o,
    output logic              hit_o,
    output logic              eq_o
);
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              vld_q;
    logic              wr;

    assign wr = wr_en_i && (cfg_idx_i == IDX_W'(IDX));

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (wr) begin
            addr_q <= cfg_addr_i;
            data_q <= cfg_data_i;
            vld_q  <= cfg_vld_i;
        end
    end

`ifdef MWC_BYTE_MASK_EN
    localparam int NB = DATA_W / 8;
    logic [NB-1:0] mask_q;
    logic [NB-1:0] byte_ok;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)   mask_q <= '0;
        else if (wr) mask_q <= cfg_mask_i;
    end

    // A cleared mask bit makes that byte a don't-care.
    for (genvar b = 0; b < NB; b++) begin : g_byte
        assign byte_ok[b] = ~mask_q[b] | (data_q[8*b +: 8] == mem_wdata_i[8*b +: 8]);
    end
    assign eq_o = &byte_ok;
`else
    assign eq_o = (data_q == mem_wdata_i);
`endif

    assign vld_o = vld_q;
    assign hit_o = vld_q && (addr_q == mem_addr_i);
endmodule

module mem_write_checker #(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int          NUM_CHK    = 4,
    parameter int          TMO_W      = 24,
    parameter int unsigned TMO_CYCLES = 1000000,
    localparam int         IDX_W      = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0]  cfg_data,
    input  logic               cfg_vld,
`ifdef MWC_BYTE_MASK_EN
    input  logic [DATA_W/8-1:0] cfg_mask,
`endif
    input  logic               mem_valid,
    input  logic               mem_we,
    input  logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_wdata,
    output logic [1:0]         state,
    output logic               success,
    output logic               fail,
    output logic               timeout,
    output logic [NUM_CHK-1:0] pass_mask,
    output logic [IDX_W-1:0]   fail_idx,
    output logic [ADDR_W-1:0]  fail_addr,
    output logic [DATA_W-1:0]  fail_data,
    output logic [TMO_W-1:0]   cyc_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_PASS  = 2'd2;
    localparam logic [1:0] S_FAIL  = 2'd3;
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYCLES);

    logic [1:0]         state_q, state_d;
    logic               success_q, success_d;
    logic               fail_q, fail_d;
    logic               timeout_q, timeout_d;
    logic [NUM_CHK-1:0] pass_mask_q, pass_mask_d;
    logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;
    logic [ADDR_W-1:0]  fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]  fail_data_q, fail_data_d;
    logic [TMO_W-1:0]   cyc_q, cyc_d;

    logic [NUM_CHK-1:0] ent_vld, ent_hit, ent_eq;
    logic               tbl_wr;
    logic               found, sel_eq, store;
    logic [IDX_W-1:0]   sel_idx;

    assign tbl_wr = cfg_we && (state_q == S_IDLE);
    assign store  = mem_valid && mem_we;

    for (genvar i = 0; i < NUM_CHK; i++) begin : g_ent
        mwc_entry #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W),
            .IDX    (i)
        ) u_ent (
            .sysclk      (sysclk),
            .reset       (reset),
            .wr_en_i     (tbl_wr),
            .cfg_idx_i   (cfg_idx),
            .cfg_addr_i  (cfg_addr),
            .cfg_data_i  (cfg_data),
            .cfg_vld_i   (cfg_vld),
`ifdef MWC_BYTE_MASK_EN
            .cfg_mask_i  (cfg_mask),
`endif
            .mem_addr_i  (mem_addr),
            .mem_wdata_i (mem_wdata),
            .vld_o       (ent_vld[i]),
            .hit_o       (ent_hit[i]),
            .eq_o        (ent_eq[i])
        );
    end

    // Descending scan so the lowest-index hit is the one left standing.
    always_comb begin
        found   = 1'b0;
        sel_eq  = 1'b0;
        sel_idx = '0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (ent_hit[i]) begin
                found   = 1'b1;
                sel_eq  = ent_eq[i];
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timeout_d   = timeout_q;
        pass_mask_d = pass_mask_q;
        fail_idx_d  = fail_idx_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        cyc_d       = cyc_q;
        if (clear) begin
            state_d   = S_IDLE;
            timeout_d = 1'b0;
        end else if (start) begin
            state_d     = S_ARMED;
            timeout_d   = 1'b0;
            pass_mask_d = '0;
            fail_idx_d  = '0;
            fail_addr_d = '0;
            fail_data_d = '0;
            cyc_d       = '0;
        end else if (state_q == S_ARMED) begin
            if (mem_valid && (cyc_q != {TMO_W{1'b1}}))
                cyc_d = cyc_q + TMO_W'(1);
            if (store && found && !sel_eq) begin
                state_d     = S_FAIL;
                fail_idx_d  = sel_idx;
                fail_addr_d = mem_addr;
                fail_data_d = mem_wdata;
            end else begin
                if (store && found)
                    pass_mask_d[sel_idx] = 1'b1;
                // Coverage looks at the registered mask, giving PASS its one-cycle latency.
                if ((pass_mask_q & ent_vld) == ent_vld)
                    state_d = S_PASS;
                else if ((TMO_CYCLES != 0) && (cyc_q == TMO_LIM)) begin
                    state_d   = S_FAIL;
                    timeout_d = 1'b1;
                end
            end
        end
        success_d = (state_d == S_PASS);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            success_q   <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            pass_mask_q <= '0;
            fail_idx_q  <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            success_q   <= success_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            pass_mask_q <= pass_mask_d;
            fail_idx_q  <= fail_idx_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            cyc_q       <= cyc_d;
        end
    end

    assign state     = state_q;
    assign success   = success_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign pass_mask = pass_mask_q;
    assign fail_idx  = fail_idx_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign cyc_cnt   = cyc_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench for mem_write_checker: expectations are queued with the stimulus and
// drained against the DUT outputs once the corresponding edge has happened.

module tb_mem_write_checker;
    localparam int AW = 32, DW = 32, NC = 4, TW = 24, TMO = 10, IW = 2;
    localparam int F_STATE = 0, F_SUCC = 1, F_FAIL = 2, F_TMO = 3, F_PMASK = 4;
    localparam int F_FIDX = 5, F_FADDR = 6, F_FDATA = 7, F_CYC = 8;

    logic          sysclk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0, clear = 1'b0;
    logic          cfg_we = 1'b0, cfg_vld = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
`ifdef MWC_BYTE_MASK_EN
    logic [DW/8-1:0] cfg_mask = '1;
`endif
    logic          mem_valid = 1'b0, mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [1:0]    state;
    logic          success, fail, timeout;
    logic [NC-1:0] pass_mask;
    logic [IW-1:0] fail_idx;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [TW-1:0] cyc_cnt;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          sel;
        logic [63:0] val;
        string       tag;
    } exp_t;
    exp_t sbq[$];

    mem_write_checker #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_CHK(NC), .TMO_W(TW), .TMO_CYCLES(TMO)
    ) dut (
        .sysclk(sysclk), .reset(reset), .start(start), .clear(clear),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_vld(cfg_vld),
`ifdef MWC_BYTE_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .state(state), .success(success), .fail(fail), .timeout(timeout),
        .pass_mask(pass_mask), .fail_idx(fail_idx), .fail_addr(fail_addr),
        .fail_data(fail_data), .cyc_cnt(cyc_cnt)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] get(input int sel);
        case (sel)
            F_STATE: return 64'(state);
            F_SUCC:  return 64'(success);
            F_FAIL:  return 64'(fail);
            F_TMO:   return 64'(timeout);
            F_PMASK: return 64'(pass_mask);
            F_FIDX:  return 64'(fail_idx);
            F_FADDR: return 64'(fail_addr);
            F_FDATA: return 64'(fail_data);
            default: return 64'(cyc_cnt);
        endcase
    endfunction

    task automatic expect_q(input int sel, input logic [63:0] val, input string tag);
        exp_t e;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, get(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic load(input int idx, input int addr, input int data, input logic vld);
        cfg_we   = 1'b1;
        cfg_idx  = IW'(idx);
        cfg_addr = AW'(addr);
        cfg_data = DW'(data);
        cfg_vld  = vld;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic store(input int addr, input int data);
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = AW'(addr);
        mem_wdata = DW'(data);
        tick();
        mem_valid = 1'b0;
        mem_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Bounded wait on an output; an expired budget shows up as a failed comparison.
    task automatic wait_out(input int sel, input logic [63:0] val, input int budget, input string tag);
        int n = 0;
        while (get(sel) !== val && n < budget) begin
            tick();
            n++;
        end
        chk(tag, get(sel), val);
    endtask

    initial begin
        #2;
        expect_q(F_STATE, 0, "rst_state");  expect_q(F_SUCC, 0, "rst_succ");
        expect_q(F_FAIL, 0, "rst_fail");    expect_q(F_TMO, 0, "rst_tmo");
        expect_q(F_PMASK, 0, "rst_pmask");  expect_q(F_FIDX, 0, "rst_fidx");
        expect_q(F_FADDR, 0, "rst_faddr");  expect_q(F_FDATA, 0, "rst_fdata");
        expect_q(F_CYC, 0, "rst_cyc");
        drain();
        tick();
        reset = 1'b0;

        // single entry pass, plus a harmless re-hit during the PASS latency cycle
        load(0, 100, 25, 1'b1);
        pulse_start();
        expect_q(F_STATE, 1, "t1_armed"); drain();
        store(100, 25);
        expect_q(F_PMASK, 1, "t1_pmask"); expect_q(F_SUCC, 0, "t1_succ_lat");
        expect_q(F_STATE, 1, "t1_state_lat"); drain();
        store(100, 25);
        expect_q(F_SUCC, 1, "t1_succ"); expect_q(F_STATE, 2, "t1_pass");
        expect_q(F_FAIL, 0, "t1_nofail"); drain();

        // data mismatch, capture, FAIL stickiness
        pulse_start();
        expect_q(F_STATE, 1, "t2_rearm"); expect_q(F_PMASK, 0, "t2_pmask_clr"); drain();
        store(100, 24);
        expect_q(F_FAIL, 1, "t2_fail");    expect_q(F_SUCC, 0, "t2_nosucc");
        expect_q(F_STATE, 3, "t2_state");  expect_q(F_FADDR, 100, "t2_faddr");
        expect_q(F_FDATA, 24, "t2_fdata"); expect_q(F_FIDX, 0, "t2_fidx");
        expect_q(F_TMO, 0, "t2_tmo"); drain();
        store(100, 25);
        expect_q(F_STATE, 3, "t2_sticky"); expect_q(F_PMASK, 0, "t2_ignored"); drain();

        // two entries, unrelated store ignored, config write in ARMED dropped
        pulse_clear();
        expect_q(F_STATE, 0, "t3_idle"); expect_q(F_FAIL, 0, "t3_fail_clr"); drain();
        load(1, 104, 7, 1'b1);
        pulse_start();
        expect_q(F_FADDR, 0, "t3_cap_clr"); expect_q(F_FDATA, 0, "t3_capd_clr"); drain();
        store(96, 1);
        expect_q(F_PMASK, 0, "t3_ign"); drain();
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_addr = 200; cfg_data = 5; cfg_vld = 1'b1;
        store(104, 7);
        cfg_we = 1'b0;
        expect_q(F_PMASK, 2, "t3_pmask2"); drain();
        store(100, 25);
        expect_q(F_PMASK, 3, "t3_pmask3"); expect_q(F_SUCC, 0, "t3_succ_lat"); drain();
        tick();
        expect_q(F_SUCC, 1, "t3_succ"); expect_q(F_STATE, 2, "t3_pass"); drain();

        // shared address: only the lowest index is checked, so entry 3 never passes
        pulse_clear();
        load(3, 100, 26, 1'b1);
        pulse_start();
        store(100, 25);
        expect_q(F_PMASK, 1, "sh_pmask"); expect_q(F_FAIL, 0, "sh_nofail"); drain();
        store(104, 7);
        tick();
        expect_q(F_PMASK, 3, "sh_pmask3"); expect_q(F_STATE, 1, "sh_armed"); drain();
        pulse_clear();
        load(3, 0, 0, 1'b0);

        // timeout counts only mem_valid cycles
        pulse_start();
        repeat (20) tick();
        expect_q(F_CYC, 0, "t4_cyc_hold"); expect_q(F_STATE, 1, "t4_armed"); drain();
        mem_valid = 1'b1;
        repeat (TMO) tick();
        mem_valid = 1'b0;
        expect_q(F_CYC, TMO, "t4_cyc"); expect_q(F_STATE, 1, "t4_pre"); drain();
        tick();
        expect_q(F_STATE, 3, "t4_state"); expect_q(F_FAIL, 1, "t4_fail");
        expect_q(F_TMO, 1, "t4_tmo"); drain();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        expect_q(F_CYC, TMO, "t4_freeze"); drain();

        // mismatch in the timeout cycle wins; start+clear goes to IDLE
        pulse_start();
        expect_q(F_TMO, 0, "t5_tmo_clr"); expect_q(F_FAIL, 0, "t5_fail_clr"); drain();
        mem_valid = 1'b1;
        repeat (TMO) tick();
        store(104, 99);
        expect_q(F_STATE, 3, "t5_state"); expect_q(F_TMO, 0, "t5_tmo");
        expect_q(F_FAIL, 1, "t5_fail");   expect_q(F_FADDR, 104, "t5_faddr");
        expect_q(F_FDATA, 99, "t5_fdata"); expect_q(F_FIDX, 1, "t5_fidx"); drain();
        start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        expect_q(F_STATE, 0, "t5_clrwins"); drain();

        // asynchronous reset mid-run wipes the table as well
        pulse_start();
        store(100, 25);
        reset = 1'b1;
        #1;
        expect_q(F_STATE, 0, "t6_state"); expect_q(F_PMASK, 0, "t6_pmask");
        expect_q(F_CYC, 0, "t6_cyc");     expect_q(F_FAIL, 0, "t6_fail"); drain();
        tick();
        reset = 1'b0;
        pulse_start();
        expect_q(F_STATE, 1, "t6_armed"); drain();
        tick();
        expect_q(F_STATE, 2, "t6_empty_pass"); expect_q(F_SUCC, 1, "t6_succ"); drain();

        // byte mask: only the low byte is compared when the feature is built in
        pulse_clear();
`ifdef MWC_BYTE_MASK_EN
        cfg_mask = 4'b0001;
`endif
        load(0, 100, 25, 1'b1);
        pulse_start();
        store(100, 32'hFF25);
`ifdef MWC_BYTE_MASK_EN
        wait_out(F_SUCC, 1, 5, "mask_succ");
`else
        wait_out(F_FAIL, 1, 5, "nomask_fail");
        expect_q(F_FDATA, 32'hFF25, "nomask_fdata"); drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
